// File: rtl/sram_axi_bridge_mc.sv
// sram_axi_bridge_mc: NUM_CH SRAM-like request channels onto one AXI3 master.
// Round-robin grant, one single-beat transaction in flight, channel index
// used as the AXI ID, bus errors reported on ch_err with the completion.
module sram_axi_bridge_mc #(
   parameter int NUM_CH = 2
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   // SRAM-like request side
   input  logic [NUM_CH-1:0]      ch_req,
   input  logic [NUM_CH-1:0]      ch_wr,
   input  logic [2*NUM_CH-1:0]    ch_size,
   input  logic [32*NUM_CH-1:0]   ch_addr,
   input  logic [32*NUM_CH-1:0]   ch_wdata,
   output logic [NUM_CH-1:0]      ch_addr_ok,
   output logic [NUM_CH-1:0]      ch_data_ok,
   output logic [31:0]            ch_rdata,
   output logic                   ch_err,
   // AR
   output logic [3:0]             arid,
   output logic [31:0]            araddr,
   output logic [3:0]             arlen,
   output logic [2:0]             arsize,
   output logic [1:0]             arburst,
   output logic [1:0]             arlock,
   output logic [3:0]             arcache,
   output logic [2:0]             arprot,
   output logic                   arvalid,
   input  logic                   arready,
   // R
   input  logic [3:0]             rid,
   input  logic [31:0]            rdata,
   input  logic [1:0]             rresp,
   input  logic                   rlast,
   input  logic                   rvalid,
   output logic                   rready,
   // AW
   output logic [3:0]             awid,
   output logic [31:0]            awaddr,
   output logic [3:0]             awlen,
   output logic [2:0]             awsize,
   output logic [1:0]             awburst,
   output logic [1:0]             awlock,
   output logic [3:0]             awcache,
   output logic [2:0]             awprot,
   output logic                   awvalid,
   input  logic                   awready,
   // W
   output logic [3:0]             wid,
   output logic [31:0]            wdata,
   output logic [3:0]             wstrb,
   output logic                   wlast,
   output logic                   wvalid,
   input  logic                   wready,
   // B
   input  logic [3:0]             bid,
   input  logic [1:0]             bresp,
   input  logic                   bvalid,
   output logic                   bready
);

   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [3:0]        id_q, id_d;
   logic [31:0]       addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic [NUM_CH-1:0] data_ok_q, data_ok_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              gnt_vld;
   logic [PW-1:0]     gnt_idx;
   logic [PW-1:0]     scan;
   logic [1:0]        gnt_size;

   // rid/rlast/bid carry nothing we need with a single outstanding beat
   logic              unused_ok;
   assign unused_ok = ^{rid, rlast, bid};

   // Per-channel views of the packed operand buses
   logic [31:0] addr_a  [NUM_CH];
   logic [31:0] wdata_a [NUM_CH];
   logic [1:0]  size_a  [NUM_CH];

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign addr_a[k]     = ch_addr[32*k +: 32];
      assign wdata_a[k]    = ch_wdata[32*k +: 32];
      assign size_a[k]     = ch_size[2*k +: 2];
      // Grant is combinational and only offered while idle and out of reset
      assign ch_addr_ok[k] = aresetn && (state_q == S_IDLE) && gnt_vld
                             && (gnt_idx == PW'(k));
   end

   // Byte-lane strobe for the latched size/address
   function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'd0:    strb_of = 4'b0001 << a;
         2'd1:    strb_of = 4'b0011 << {a[1], 1'b0};
         default: strb_of = 4'b1111;
      endcase
   endfunction

   // Round-robin pick: first requester at or after rr_ptr, wrapping
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         scan = PW'((int'(rr_ptr_q) + i) % NUM_CH);
         if (!gnt_vld && ch_req[scan]) begin
            gnt_vld = 1'b1;
            gnt_idx = scan;
         end
      end
   end

   // Size 3 is treated as a word
   assign gnt_size = (size_a[gnt_idx] == 2'd3) ? 2'd2 : size_a[gnt_idx];

   // Next-state and registered-output logic for the transaction FSM
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      addr_d    = addr_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      data_ok_d = '0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               id_d    = 4'(gnt_idx);
               addr_d  = addr_a[gnt_idx];
               size_d  = gnt_size;
               wdata_d = wdata_a[gnt_idx];
               wstrb_d = strb_of(gnt_size, addr_a[gnt_idx][1:0]);
               if (int'(gnt_idx) == NUM_CH - 1) rr_ptr_d = '0;
               else                             rr_ptr_d = gnt_idx + 1'b1;
               if (ch_wr[gnt_idx]) begin
                  state_d   = S_AW_W;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_AR;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_AR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_R;
            end
         end
         S_R: begin
            if (rvalid) begin
               rready_d = 1'b0;
               rdata_d  = rdata;
               err_d    = |rresp;
               for (int k = 0; k < NUM_CH; k++) data_ok_d[k] = (id_q == 4'(k));
               state_d  = S_DONE;
            end
         end
         S_AW_W: begin
            // AW and W retire independently; leave once neither is pending
            if (awready) awvalid_d = 1'b0;
            if (wready)  wvalid_d  = 1'b0;
            if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
               bready_d = 1'b1;
               state_d  = S_B;
            end
         end
         S_B: begin
            if (bvalid) begin
               bready_d = 1'b0;
               err_d    = |bresp;
               for (int k = 0; k < NUM_CH; k++) data_ok_d[k] = (id_q == 4'(k));
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         id_q      <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         data_ok_q <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign arid    = id_q;
   assign araddr  = addr_q;
   assign arlen   = 4'd0;
   assign arsize  = {1'b0, size_q};
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;

   assign awid    = id_q;
   assign awaddr  = addr_q;
   assign awlen   = 4'd0;
   assign awsize  = {1'b0, size_q};
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;
   assign awvalid = awvalid_q;

   assign wid     = id_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_q;
   assign bready  = bready_q;

   assign ch_data_ok = data_ok_q;
   assign ch_rdata   = rdata_q;
   assign ch_err     = err_q;

endmodule

// File: tb/tb_sram_axi_bridge_mc.sv
// Directed bench for sram_axi_bridge_mc with NUM_CH=4 and a hand-driven AXI slave.
module tb_sram_axi_bridge_mc;
   localparam int N = 4;

   logic            aclk, aresetn;
   logic [N-1:0]    ch_req, ch_wr, ch_addr_ok, ch_data_ok;
   logic [2*N-1:0]  ch_size;
   logic [32*N-1:0] ch_addr, ch_wdata;
   logic [31:0]     ch_rdata;
   logic            ch_err;
   logic [3:0]      arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
   logic [31:0]     araddr, awaddr, wdata, rdata;
   logic [2:0]      arsize, arprot, awsize, awprot;
   logic [1:0]      arburst, arlock, awburst, awlock, rresp, bresp;
   logic            arvalid, arready, rlast, rvalid, rready;
   logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int n_chk = 0;
   int n_err = 0;

   sram_axi_bridge_mc #(.NUM_CH(N)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
      .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
      .ch_rdata(ch_rdata), .ch_err(ch_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask

   // Land 1 time unit after the rising edge
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic read_txn(input int ch, input logic [31:0] a, input logic [1:0] sz,
                           input int ar_dly, input int r_dly, input logic [31:0] d,
                           input logic [1:0] resp, input logic exp_err, input logic [2:0] exp_sz);
      ch_req[ch] = 1'b1; ch_wr[ch] = 1'b0;
      ch_addr[ch*32 +: 32] = a; ch_size[ch*2 +: 2] = sz;
      #1; chk("rd_addr_ok", 32'(ch_addr_ok), 32'(1 << ch));
      tick();
      ch_req[ch] = 1'b0;
      for (int c = 0; c <= ar_dly; c++) begin
         arready = (c == ar_dly);
         #1;
         chk("rd_arvalid", 32'(arvalid), 1);
         chk("rd_rready_early", 32'(rready), 0);
         if (c == 0) begin
            chk("rd_arid", 32'(arid), 32'(ch));
            chk("rd_araddr", araddr, a);
            chk("rd_arsize", 32'(arsize), 32'(exp_sz));
            chk("rd_arlen", 32'(arlen), 0);
            chk("rd_arburst", 32'(arburst), 1);
         end
         tick();
      end
      arready = 1'b0;
      for (int c = 0; c <= r_dly; c++) begin
         rvalid = (c == r_dly); rdata = d; rresp = resp;
         #1;
         chk("rd_rready", 32'(rready), 1);
         chk("rd_arvalid_drop", 32'(arvalid), 0);
         chk("rd_data_ok_early", 32'(ch_data_ok), 0);
         tick();
      end
      rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
      #1;
      chk("rd_data_ok", 32'(ch_data_ok), 32'(1 << ch));
      chk("rd_rdata", ch_rdata, d);
      chk("rd_err", 32'(ch_err), 32'(exp_err));
      tick();
      chk("rd_data_ok_pulse", 32'(ch_data_ok), 0);
      chk("rd_err_held", 32'(ch_err), 32'(exp_err));
      chk("rd_rdata_held", ch_rdata, d);
   endtask

   task automatic write_txn(input int ch, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d, input int aw_dly, input int w_dly,
                            input logic [3:0] exp_strb, input logic [2:0] exp_sz);
      int last;
      last = (aw_dly > w_dly) ? aw_dly : w_dly;
      ch_req[ch] = 1'b1; ch_wr[ch] = 1'b1;
      ch_addr[ch*32 +: 32] = a; ch_size[ch*2 +: 2] = sz; ch_wdata[ch*32 +: 32] = d;
      #1; chk("wr_addr_ok", 32'(ch_addr_ok), 32'(1 << ch));
      tick();
      ch_req[ch] = 1'b0;
      for (int c = 0; c <= last; c++) begin
         awready = (c >= aw_dly); wready = (c >= w_dly);
         #1;
         chk("wr_awvalid", 32'(awvalid), 32'(c <= aw_dly));
         chk("wr_wvalid", 32'(wvalid), 32'(c <= w_dly));
         chk("wr_bready_early", 32'(bready), 0);
         if (c == 0) begin
            chk("wr_awid", 32'(awid), 32'(ch));
            chk("wr_wid", 32'(wid), 32'(ch));
            chk("wr_awaddr", awaddr, a);
            chk("wr_wdata", wdata, d);
            chk("wr_wstrb", 32'(wstrb), 32'(exp_strb));
            chk("wr_awsize", 32'(awsize), 32'(exp_sz));
            chk("wr_wlast", 32'(wlast), 1);
         end
         tick();
      end
      awready = 1'b0; wready = 1'b0;
      bvalid = 1'b1; bresp = 2'b00;
      #1;
      chk("wr_bready", 32'(bready), 1);
      chk("wr_valids_done", 32'({awvalid, wvalid}), 0);
      chk("wr_data_ok_early", 32'(ch_data_ok), 0);
      tick();
      bvalid = 1'b0;
      #1;
      chk("wr_data_ok", 32'(ch_data_ok), 32'(1 << ch));
      chk("wr_err", 32'(ch_err), 0);
      tick();
      chk("wr_data_ok_pulse", 32'(ch_data_ok), 0);
   endtask

   initial begin
      int wc;
      int exp_g [5];
      exp_g = '{0, 1, 2, 3, 0};
      aresetn = 1'b0;
      ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
      arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

      // Reset state
      #12;
      chk("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 0);
      chk("rst_addr_ok", 32'(ch_addr_ok), 0);
      chk("rst_data_ok", 32'(ch_data_ok), 0);
      chk("rst_rdata", ch_rdata, 0);
      chk("rst_err", 32'(ch_err), 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_wstrb", 32'(wstrb), 0);
      chk("rst_ids", 32'({arid, awid, wid}), 0);
      tick();
      aresetn = 1'b1;

      // Single word read, zero wait states
      read_txn(0, 32'h1FC0_0004, 2'd2, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 3'd2);

      // Byte and half writes, then handshake orders
      write_txn(1, 32'h8000_0003, 2'd0, 32'hAA00_0000, 0, 0, 4'b1000, 3'd0);
      write_txn(1, 32'h8000_0002, 2'd1, 32'hBBBB_0000, 0, 0, 4'b1100, 3'd1);
      write_txn(1, 32'h8000_0010, 2'd2, 32'h1111_2222, 0, 3, 4'b1111, 3'd2);
      write_txn(1, 32'h8000_0014, 2'd2, 32'h3333_4444, 3, 0, 4'b1111, 3'd2);
      write_txn(1, 32'h8000_0018, 2'd3, 32'h5555_6666, 2, 2, 4'b1111, 3'd2);

      // Stalled read with SLVERR, then a clean read clears ch_err
      read_txn(2, 32'h0000_1002, 2'd1, 1, 5, 32'h0BAD_0BAD, 2'b10, 1'b1, 3'd1);
      read_txn(3, 32'h0000_2001, 2'd0, 0, 0, 32'h0000_0055, 2'b00, 1'b0, 3'd0);

      // Reset while waiting in R
      ch_req[1] = 1'b1; ch_wr[1] = 1'b0; ch_addr[32 +: 32] = 32'h0000_3000; ch_size[2 +: 2] = 2'd2;
      #1; chk("mr_addr_ok", 32'(ch_addr_ok), 32'b0010);
      tick();
      ch_req[1] = 1'b0; arready = 1'b1;
      tick();
      arready = 1'b0;
      #1; chk("mr_in_r", 32'(rready), 1);
      aresetn = 1'b0; ch_req = 4'b1111;
      #1;
      chk("mr_arvalid", 32'(arvalid), 0);
      chk("mr_rready", 32'(rready), 0);
      chk("mr_data_ok", 32'(ch_data_ok), 0);
      chk("mr_addr_ok", 32'(ch_addr_ok), 0);
      tick(); tick();
      aresetn = 1'b1;

      // All four requesting: grants 0,1,2,3,0, back to back
      arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
      for (int n = 0; n < 5; n++) begin
         #1;
         wc = 0;
         while (ch_addr_ok == '0 && wc < 8) begin
            tick();
            wc++;
         end
         chk("rr_grant", 32'(ch_addr_ok), 32'(1 << exp_g[n]));
         if (n > 0) chk("rr_b2b", 32'(wc), 0);
         tick(); tick(); tick();
         chk("rr_data_ok", 32'(ch_data_ok), 32'(1 << exp_g[n]));
         chk("rr_no_grant_done", 32'(ch_addr_ok), 0);
         chk("rr_rdata", ch_rdata, 32'h1234_5678);
         tick();
      end

      // Pointer now at 1: ch2 wins, then the scan wraps to ch0
      ch_req = 4'b0101;
      #1; chk("rr_pair_first", 32'(ch_addr_ok), 32'b0100);
      tick(); tick(); tick();
      chk("rr_pair_done", 32'(ch_data_ok), 32'b0100);
      tick();
      chk("rr_pair_wrap", 32'(ch_addr_ok), 32'b0001);
      ch_req = '0;
      tick(); tick(); tick(); tick();
      arready = 1'b0; rvalid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/sram_axi_bridge_mc.md
# sram_axi_bridge_mc

Parametrised multi-channel bridge from the core's SRAM-like request channels to a single AXI3 master port. It generalises the fixed two-port (instruction/data) CPU-to-AXI adapter to NUM_CH requesters, adds round-robin arbitration, per-channel AXI IDs and bus-error reporting. It sits between the `mips` core (and any future requester, e.g. a DMA or a second core) and the system interconnect. One transaction is outstanding at a time, and every transfer is a single beat.

## Interface
Parameters:
- NUM_CH, 2, number of SRAM-like channels (1..16); channel index is the AXI ID.

Ports (channel-indexed vectors are packed; channel k occupies slice k):
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- ch_req  in  NUM_CH  request valid per channel
- ch_wr  in  NUM_CH  1 = write
- ch_size  in  2*NUM_CH  0 byte, 1 half, 2 word, 3 treated as word
- ch_addr  in  32*NUM_CH  byte address
- ch_wdata  in  32*NUM_CH  write data, in the same lane as the address
- ch_addr_ok  out  NUM_CH  request accepted; one-hot or zero
- ch_data_ok  out  NUM_CH  transaction complete; one-hot or zero
- ch_rdata  out  32  read data, shared; valid while ch_data_ok is set
- ch_err  out  1  high together with ch_data_ok if rresp/bresp != 0
- AR: arid[3:0], araddr[31:0], arlen[3:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid out; arready in
- R: rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid in; rready out
- AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid out (widths as AR); awready in
- W: wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid out; wready in
- B: bid[3:0], bresp[1:0], bvalid in; bready out

## Operation
- States: IDLE, AR, R, AW_W, B, DONE.
- IDLE: if any ch_req is high, grant the first requesting channel at or after rr_ptr, scanning upward and wrapping.
  - ch_addr_ok[g] is high combinationally in the same cycle.
  - Latch the ID, address, size and wdata of channel g.
  - Set rr_ptr = (g+1) mod NUM_CH.
  - Next state is AR for a read and AW_W for a write.
- AR: arvalid=1; move to R on arready.
- R: rready=1; on rvalid, latch rdata and rresp and move to DONE. rid and rlast are ignored.
- AW_W: awvalid and wvalid are both asserted on entry.
  - Each is dropped independently after its own handshake.
  - Move to B once both handshakes are done; they may complete in the same cycle or in either order.
- B: bready=1; on bvalid, latch bresp and move to DONE.
- DONE: ch_data_ok[id]=1 for exactly one cycle; ch_rdata holds the latched rdata; ch_err = (resp != 0). Next state is IDLE.
- Fixed fields:
  - arlen/awlen=0, arburst/awburst=2'b01, arlock/awlock=0, arcache/awcache=0, arprot/awprot=0, wlast=1.
  - wid=awid=arid = latched ID; arsize/awsize = {1'b0, size}, with size 3 mapped to 2.
- wstrb:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Addresses are passed through unaligned; alignment is the requester's responsibility.
- ch_rdata and ch_err are held between completions.

## Timing
- Reset (async assert):
  - state=IDLE, rr_ptr=0.
  - All valid/ready outputs low, all ch_addr_ok/ch_data_ok low.
  - ch_rdata=0, ch_err=0, all AXI address/data/ID outputs 0.
- Reset asserted mid-transaction abandons it; no data_ok is produced. Releasing reset is synchronised by the system.
- ch_addr_ok is asserted only in IDLE; at most one grant per transaction.
- Minimum read latency, from the addr_ok cycle T:
  - arvalid at T+1; with arready=1, rready at T+2.
  - With rvalid=1, data_ok at T+3.
- Minimum write latency is the same: AW/W at T+1, B at T+2, data_ok at T+3.
- Back-to-back: the next grant occurs at the earliest in the cycle after DONE.
- A requester must hold ch_req and its operands until ch_addr_ok; the bridge never needs them afterwards.
- rvalid/bvalid arriving outside R/B is not accepted (ready is low).
- AXI valids stay asserted until their handshake, with payload stable.

## Test plan
- Single read: ch0 reads 0x1FC00004 size 2; slave returns 0xDEADBEEF with zero wait states → arid=0, arsize=2, data_ok[0] at T+3, ch_rdata=0xDEADBEEF, ch_err=0.
- Byte and half writes: ch1 writes addr 0x80000003 size 0, then 0x80000002 size 1 → wstrb=4'b1000, then 4'b1100, awid=wid=1, data_ok[1] after each bvalid.
- Write handshake order: awready 3 cycles before wready, then the reverse order, then both in the same cycle → each valid drops after its own handshake, bready rises only after both, exactly one data_ok per write.
- Round-robin: NUM_CH=4, all four channels request continuously → grants 0,1,2,3,0; with only ch2 and ch0 requesting after a grant to ch2, the next grant goes to ch0.
- Error and stalls: rvalid delayed 5 cycles with rresp=2'b10 → rready is held, data_ok pulses for 1 cycle with ch_err=1; the next OK read clears ch_err to 0.
- Reset mid-read: drop aresetn while in R → arvalid, rready and every ch_data_ok go to 0 immediately; after release, a new read completes normally with the grant taken from ch0 (rr_ptr=0).
